// File: rtl/sm4_pipe_pkg.sv
// sm4_pipe_pkg: shared sizing helpers, lane slicing and depth reset constant for the SM4 delay pipe
package sm4_pipe_pkg;
  localparam int MAX_DEPTH_DEF = 8;
  function automatic int cnt_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
  function automatic int lane_lsb(input int k, input int word_width);
    return k * word_width;
  endfunction
endpackage

// File: rtl/delay_var_stage.sv
// delay_var_stage: one {v,d} pipe register with shift enable, valid clear and optional data reset (DELAY_VAR_PIPE_DATA_RST_EN)
module delay_var_stage
  import sm4_pipe_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         v,
  output logic [W-1:0] d
);
  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;
  always_comb begin
    v_d = clr ? 1'b0 : en ? in_v : v_q;
    d_d = en ? in_d : d_q;
  end
`ifdef DELAY_VAR_PIPE_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= 1'b0;
    else v_q <= v_d;
  end
  always_ff @(posedge clk) d_q <= d_d;
`endif
  assign v = v_q;
  assign d = d_q;
endmodule

// File: rtl/delay_var_pipe.sv
// delay_var_pipe: runtime-depth (1..MAX_DEPTH) delay line with stall, flush, inflight count and guarded reconfig; option DELAY_VAR_PIPE_DATA_RST_EN
module delay_var_pipe
  import sm4_pipe_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int MAX_DEPTH   = MAX_DEPTH_DEF,
  parameter int TOTAL_WIDTH = WORD_WIDTH * NUM_CH,
  parameter int CNT_W       = cnt_w(MAX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [TOTAL_WIDTH-1:0] in_data,
  input  logic                   cfg_load,
  input  logic [CNT_W-1:0]       cfg_depth,
  output logic                   out_valid,
  output logic [TOTAL_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       depth,
  output logic [CNT_W-1:0]       inflight,
  output logic                   busy,
  output logic                   cfg_err
);
  logic                   c_v [MAX_DEPTH+1];
  logic [TOTAL_WIDTH-1:0] c_d [MAX_DEPTH+1];
  logic                   shift, clr, cfg_ok;
  logic [CNT_W-1:0]       depth_q, depth_d, inflight_q, inflight_d;
  logic                   cfg_err_q, cfg_err_d;
  assign c_v[0] = in_valid;
  assign c_d[0] = in_data;
  assign shift  = !stall && !flush;
  assign clr    = flush || cfg_ok;
  for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_st
    delay_var_stage #(.W(TOTAL_WIDTH)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (shift),
      .clr  (clr),
      .in_v (c_v[g]),
      .in_d (c_d[g]),
      .v    (c_v[g+1]),
      .d    (c_d[g+1])
    );
  end
  always_comb begin
    out_valid = c_v[1];
    out_data  = c_d[1];
    for (int i = 2; i <= MAX_DEPTH; i++) begin
      if (depth_q == CNT_W'(i)) begin
        out_valid = c_v[i];
        out_data  = c_d[i];
      end
    end
  end
  always_comb begin
    cfg_ok     = cfg_load && inflight_q == '0 && !in_valid && !flush &&
                 cfg_depth != '0 && cfg_depth <= CNT_W'(MAX_DEPTH);
    cfg_err_d  = cfg_load && !cfg_ok;
    depth_d    = cfg_ok ? cfg_depth : depth_q;
    inflight_d = flush ? '0 : stall ? inflight_q :
                 inflight_q + CNT_W'(in_valid) - CNT_W'(out_valid);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q    <= CNT_W'(MAX_DEPTH);
      inflight_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      depth_q    <= depth_d;
      inflight_q <= inflight_d;
      cfg_err_q  <= cfg_err_d;
    end
  end
  assign depth    = depth_q;
  assign inflight = inflight_q;
  assign busy     = inflight_q != '0;
  assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_delay_var_pipe.sv
// tb_delay_var_pipe: table-driven directed bench for delay_var_pipe with reset and mid-operation reset sequences
module tb_delay_var_pipe;
  localparam int TW = 128;
  logic          clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
  logic [TW-1:0] in_data = '0, out_data;
  logic [3:0]    cfg_depth = '0, depth, inflight;
  logic          out_valid, busy, cfg_err;
  int            checks = 0, failures = 0;
  typedef struct {
    logic st, fl, iv; logic [TW-1:0] id; logic cl; logic [3:0] cd;
    logic ov; logic [TW-1:0] od; logic [3:0] dep, inf; logic err;
  } vec_t;
  vec_t q[$];
  delay_var_pipe dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .cfg_load(cfg_load), .cfg_depth(cfg_depth), .out_valid(out_valid),
    .out_data(out_data), .depth(depth), .inflight(inflight), .busy(busy), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  function automatic logic [TW-1:0] wd(input int n);
    return {32'h1000_0000 + n, 32'h2000_0000 + n, 32'h3000_0000 + n, 32'h4000_0000 + n};
  endfunction
  task automatic chk(input string nm, input int idx, input logic [TW-1:0] a, input logic [TW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", nm, idx, a, e);
    end
  endtask
  task automatic add(input logic st, fl, iv, input logic [TW-1:0] id, input logic cl, input logic [3:0] cd,
                     input logic ov, input logic [TW-1:0] od, input logic [3:0] dep, inf, input logic err);
    q.push_back('{st, fl, iv, id, cl, cd, ov, od, dep, inf, err});
  endtask
  task automatic idle(input logic ov, input logic [TW-1:0] od, input logic [3:0] dep, inf);
    add(0, 0, 0, '0, 0, 0, ov, od, dep, inf, 0);
  endtask
  task automatic drive(input logic st, fl, iv, input logic [TW-1:0] id, input logic cl, input logic [3:0] cd);
    stall = st; flush = fl; in_valid = iv; in_data = id; cfg_load = cl; cfg_depth = cd;
  endtask
  initial begin
    add(0, 0, 1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, 0, 0, '0, 8, 1, 0);
    repeat (6) idle(0, '0, 8, 1);
    idle(1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 8, 1);
    idle(0, '0, 8, 0);
    add(0, 0, 0, '0, 1, 3, 0, '0, 3, 0, 0);
    add(0, 0, 1, wd(0), 0, 0, 0, '0, 3, 1, 0);
    add(0, 0, 1, wd(1), 0, 0, 0, '0, 3, 2, 0);
    add(0, 0, 1, wd(2), 0, 0, 1, wd(0), 3, 3, 0);
    add(0, 0, 1, wd(3), 0, 0, 1, wd(1), 3, 3, 0);
    add(0, 0, 1, wd(4), 0, 0, 1, wd(2), 3, 3, 0);
    idle(1, wd(3), 3, 2);
    idle(1, wd(4), 3, 1);
    idle(0, '0, 3, 0);
    add(0, 0, 1, wd(5), 0, 0, 0, '0, 3, 1, 0);
    idle(0, '0, 3, 1);
    add(1, 0, 1, wd(99), 0, 0, 0, '0, 3, 1, 0);
    add(1, 0, 0, '0, 0, 0, 0, '0, 3, 1, 0);
    idle(1, wd(5), 3, 1);
    add(1, 0, 0, '0, 0, 0, 1, wd(5), 3, 1, 0);
    add(1, 0, 0, '0, 0, 0, 1, wd(5), 3, 1, 0);
    repeat (3) idle(0, '0, 3, 0);
    add(0, 0, 1, wd(7), 0, 0, 0, '0, 3, 1, 0);
    add(0, 0, 1, wd(8), 0, 0, 0, '0, 3, 2, 0);
    add(0, 1, 1, wd(9), 1, 5, 0, '0, 3, 0, 1);
    repeat (4) idle(0, '0, 3, 0);
    add(0, 0, 0, '0, 1, 0, 0, '0, 3, 0, 1);
    idle(0, '0, 3, 0);
    add(0, 0, 0, '0, 1, 9, 0, '0, 3, 0, 1);
    add(0, 0, 1, wd(10), 0, 0, 0, '0, 3, 1, 0);
    add(0, 0, 0, '0, 1, 5, 0, '0, 3, 1, 1);
    idle(1, wd(10), 3, 1);
    idle(0, '0, 3, 0);
    add(0, 0, 1, wd(11), 1, 5, 0, '0, 3, 1, 1);
    idle(0, '0, 3, 1);
    idle(1, wd(11), 3, 1);
    idle(0, '0, 3, 0);
    add(1, 0, 0, '0, 1, 8, 0, '0, 8, 0, 0);
    add(0, 0, 0, '0, 1, 2, 0, '0, 2, 0, 0);
    add(0, 0, 1, wd(12), 0, 0, 0, '0, 2, 1, 0);
    idle(1, wd(12), 2, 1);
    idle(0, '0, 2, 0);
    add(0, 0, 0, '0, 1, 8, 0, '0, 8, 0, 0);
    repeat (8) idle(0, '0, 8, 0);
    add(0, 0, 1, wd(13), 0, 0, 0, '0, 8, 1, 0);
    add(1, 1, 0, '0, 0, 0, 0, '0, 8, 0, 0);
    repeat (8) idle(0, '0, 8, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", -1, TW'(out_valid), '0);
    chk("rst_depth", -1, TW'(depth), TW'(8));
    chk("rst_inflight", -1, TW'(inflight), '0);
    chk("rst_busy", -1, TW'(busy), '0);
    chk("rst_cfg_err", -1, TW'(cfg_err), '0);
`ifdef DELAY_VAR_PIPE_DATA_RST_EN
    chk("rst_out_data", -1, out_data, '0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].st, q[i].fl, q[i].iv, q[i].id, q[i].cl, q[i].cd);
      @(posedge clk);
      #1;
      chk("out_valid", i, TW'(out_valid), TW'(q[i].ov));
      if (q[i].ov) chk("out_data", i, out_data, q[i].od);
      chk("depth", i, TW'(depth), TW'(q[i].dep));
      chk("inflight", i, TW'(inflight), TW'(q[i].inf));
      chk("busy", i, TW'(busy), TW'(q[i].inf != 0));
      chk("cfg_err", i, TW'(cfg_err), TW'(q[i].err));
    end
    drive(0, 0, 0, '0, 1, 3);
    @(posedge clk);
    #1;
    chk("mid_cfg_depth", -2, TW'(depth), TW'(3));
    drive(0, 0, 1, wd(14), 0, 0);
    @(posedge clk);
    #1;
    chk("mid_inflight", -2, TW'(inflight), TW'(1));
    drive(0, 0, 0, '0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_depth", -2, TW'(depth), TW'(8));
    chk("mid_rst_inflight", -2, TW'(inflight), '0);
    chk("mid_rst_busy", -2, TW'(busy), '0);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", -2, TW'(out_valid), '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
